// File: rtl/twiddle_mult_w8_pipe.sv
// Complex multiply by the radix-8 twiddle W8^k using a shift-add 181/256 constant.
// Four register ranks: pre-add, product, round, saturate/output; all advance on a common enable.
module twiddle_mult_w8_pipe #(
    parameter int WIDTH = 16,
    parameter int ROUND = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    input  logic [2:0]              in_k,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last,
    output logic                    out_sat,
    input  logic                    sat_clr,
    output logic [15:0]             sat_cnt
);

    // Two guard bits cover -(a+b) with both operands at the negative limit.
    localparam int XW = WIDTH + 2;
    localparam int PW = XW + 8;
    localparam int RW = PW - 8;

    localparam logic signed [PW-1:0] RBIAS = PW'((ROUND != 0) ? 128 : 0);
    localparam logic signed [RW-1:0] MAXV  = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV  = {3'b111, {(WIDTH-1){1'b0}}};

    function automatic logic signed [PW-1:0] scale_c(input logic signed [XW-1:0] x,
                                                     input logic odd);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] p;
        xe = {{8{x[XW-1]}}, x};
        // 181 = 128 + 32 + 16 + 4 + 1; even twiddles are scaled by 256 so one rounding path serves all k
        if (odd)
            p = (xe <<< 7) + (xe <<< 5) + (xe <<< 4) + (xe <<< 2) + xe;
        else
            p = xe <<< 8;
        return p;
    endfunction

    function automatic logic signed [RW-1:0] round_p(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] t;
        t = p + RBIAS;
        return t[PW-1:8];
    endfunction

    function automatic logic is_clip(input logic signed [RW-1:0] v);
        return (v > MAXV) || (v < MINV);
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [RW-1:0] v);
        logic signed [WIDTH-1:0] r;
        if (v > MAXV)
            r = {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < MINV)
            r = {1'b1, {(WIDTH-1){1'b0}}};
        else
            r = v[WIDTH-1:0];
        return r;
    endfunction

    logic en;
    logic signed [XW-1:0] a_x, b_x, pre_re, pre_im;

    logic signed [XW-1:0] pre_re_p0, pre_im_p0;
    logic                 odd_p0, last_p0, vld_p0;
    logic signed [PW-1:0] prod_re_p1, prod_im_p1;
    logic                 last_p1, vld_p1;
    logic signed [RW-1:0] rnd_re_p2, rnd_im_p2;
    logic                 last_p2, vld_p2;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    assign a_x = {{2{in_re[WIDTH-1]}}, in_re};
    assign b_x = {{2{in_im[WIDTH-1]}}, in_im};

    always_comb begin
        pre_re = a_x;
        pre_im = b_x;
        case (in_k)
            3'd1: begin pre_re = a_x + b_x;    pre_im = b_x - a_x;    end
            3'd2: begin pre_re = b_x;          pre_im = -a_x;         end
            3'd3: begin pre_re = b_x - a_x;    pre_im = -(a_x + b_x); end
            3'd4: begin pre_re = -a_x;         pre_im = -b_x;         end
            3'd5: begin pre_re = -(a_x + b_x); pre_im = a_x - b_x;    end
            3'd6: begin pre_re = -b_x;         pre_im = a_x;          end
            3'd7: begin pre_re = a_x - b_x;    pre_im = a_x + b_x;    end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // S1: pre-add
            pre_re_p0  <= pre_re;
            pre_im_p0  <= pre_im;
            odd_p0     <= in_k[0];
            last_p0    <= in_last;
            // S2: shift-add product
            prod_re_p1 <= scale_c(pre_re_p0, odd_p0);
            prod_im_p1 <= scale_c(pre_im_p0, odd_p0);
            last_p1    <= last_p0;
            // S3: round
            rnd_re_p2  <= round_p(prod_re_p1);
            rnd_im_p2  <= round_p(prod_im_p1);
            last_p2    <= last_p1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else if (en) begin
            vld_p0    <= in_valid;
            vld_p1    <= vld_p0;
            vld_p2    <= vld_p1;
            // Output: saturate
            out_valid <= vld_p2;
            out_re    <= sat_w(rnd_re_p2);
            out_im    <= sat_w(rnd_im_p2);
            out_last  <= last_p2;
            out_sat   <= is_clip(rnd_re_p2) || is_clip(rnd_im_p2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (sat_clr)
            sat_cnt <= '0;
        else if (out_valid && out_ready && out_sat && (sat_cnt != 16'hFFFF))
            sat_cnt <= sat_cnt + 16'd1;
    end

endmodule
